// File: rtl/debug_port_scan_ctrl_pkg.sv
// Shared definitions for the debug-port scan controller: selection width,
// default selection limit, FSM state encoding and range helpers.
package debug_port_scan_ctrl_pkg;

    localparam int unsigned SEL_W           = 8;
    localparam int unsigned MAX_SEL_DEFAULT = 47;
    localparam int unsigned PORT_W          = 32;
    localparam int unsigned TRIG_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FROZEN = 2'd2
    } scan_state_e;

    function automatic logic range_valid(
        input logic [SEL_W-1:0] start_sel,
        input logic [SEL_W-1:0] end_sel,
        input logic [SEL_W-1:0] max_sel
    );
        return (start_sel <= end_sel) && (end_sel <= max_sel);
    endfunction

    // Out-of-range current selections restart from the range start.
    function automatic logic [SEL_W-1:0] scan_next_sel(
        input logic [SEL_W-1:0] cur_sel,
        input logic [SEL_W-1:0] start_sel,
        input logic [SEL_W-1:0] end_sel
    );
        logic [SEL_W-1:0] nxt;
        if ((cur_sel >= end_sel) || (cur_sel < start_sel)) begin
            nxt = start_sel;
        end else begin
            nxt = cur_sel + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/debug_port_scan_ctrl_trig_match.sv
// Masked compare of the upper debug half against a trigger value.
module debug_trig_match
    import debug_port_scan_ctrl_pkg::*;
(
    input  logic              enable,
    input  logic [TRIG_W-1:0] data,
    input  logic [TRIG_W-1:0] mask,
    input  logic [TRIG_W-1:0] value,
    output logic              hit
);

    // Combinational masked equality, gated by the arm bit.
    always_comb begin
        hit = enable & ((data & mask) == (value & mask));
    end

endmodule

// File: rtl/debug_port_scan_ctrl.sv
// Debug mux selection controller: static selection, auto-scan of the low
// half with per-selection dwell, and trigger freeze with capture.
module debug_port_scan_ctrl
    import debug_port_scan_ctrl_pkg::*;
#(
    parameter int unsigned MAX_SEL = MAX_SEL_DEFAULT,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               macCoreClk,
    input  logic               macCoreClkSoftRst_n,
    input  logic [SEL_W-1:0]   regSel1,
    input  logic [SEL_W-1:0]   regSel2,
    input  logic               scanEn,
    input  logic [SEL_W-1:0]   scanStart,
    input  logic [SEL_W-1:0]   scanEnd,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               trigEn,
    input  logic [TRIG_W-1:0]  trigMask,
    input  logic [TRIG_W-1:0]  trigValue,
    input  logic               trigClr,
    input  logic [PORT_W-1:0]  debugPort,
    output logic [SEL_W-1:0]   debugPortSel1,
    output logic [SEL_W-1:0]   debugPortSel2,
    output logic               scanBusy,
    output logic               scanErr,
    output logic               trigHit,
    output logic [SEL_W-1:0]   trigSel,
    output logic [PORT_W-1:0]  trigCapture
);

    localparam logic [SEL_W-1:0] MAX_SEL_C = SEL_W'(MAX_SEL);

    scan_state_e         state_r,     state_nxt_s;
    logic [SEL_W-1:0]    sel1_r,      sel1_nxt_s;
    logic [SEL_W-1:0]    sel2_r,      sel2_nxt_s;
    logic [DWELL_W-1:0]  cnt_r,       cnt_nxt_s;
    logic [DWELL_W-1:0]  dwell_lat_r, dwell_lat_nxt_s;
    logic                busy_r,      busy_nxt_s;
    logic                err_r,       err_nxt_s;
    logic                hit_r,       hit_nxt_s;
    logic [SEL_W-1:0]    trig_sel_r,  trig_sel_nxt_s;
    logic [PORT_W-1:0]   trig_cap_r,  trig_cap_nxt_s;

    logic                trig_match_s;
    logic                range_ok_s;
    logic [DWELL_W-1:0]  dwell_eff_s;

    debug_trig_match u_trig_match (
        .enable (trigEn),
        .data   (debugPort[PORT_W-1:PORT_W-TRIG_W]),
        .mask   (trigMask),
        .value  (trigValue),
        .hit    (trig_match_s)
    );

    // Range check and zero-dwell substitution for the next selection load.
    always_comb begin
        range_ok_s = range_valid(scanStart, scanEnd, MAX_SEL_C);
        if (dwell == '0) begin
            dwell_eff_s = DWELL_W'(1);
        end else begin
            dwell_eff_s = dwell;
        end
    end

    // Next-state and next-output logic; every register holds unless assigned.
    always_comb begin
        state_nxt_s     = state_r;
        sel1_nxt_s      = sel1_r;
        sel2_nxt_s      = sel2_r;
        cnt_nxt_s       = cnt_r;
        dwell_lat_nxt_s = dwell_lat_r;
        err_nxt_s       = err_r;
        hit_nxt_s       = hit_r;
        trig_sel_nxt_s  = trig_sel_r;
        trig_cap_nxt_s  = trig_cap_r;

        case (state_r)
            ST_IDLE: begin
                if (trig_match_s) begin
                    state_nxt_s    = ST_FROZEN;
                    hit_nxt_s      = 1'b1;
                    trig_sel_nxt_s = sel1_r;
                    trig_cap_nxt_s = debugPort;
                end else if (scanEn && range_ok_s) begin
                    state_nxt_s     = ST_SCAN;
                    sel1_nxt_s      = scanStart;
                    sel2_nxt_s      = regSel2;
                    cnt_nxt_s       = DWELL_W'(1);
                    dwell_lat_nxt_s = dwell_eff_s;
                    err_nxt_s       = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    sel1_nxt_s  = regSel1;
                    sel2_nxt_s  = regSel2;
                    cnt_nxt_s   = '0;
                    err_nxt_s   = scanEn;
                end
            end
            ST_SCAN: begin
                if (trig_match_s) begin
                    state_nxt_s    = ST_FROZEN;
                    hit_nxt_s      = 1'b1;
                    trig_sel_nxt_s = sel1_r;
                    trig_cap_nxt_s = debugPort;
                end else if (!scanEn) begin
                    state_nxt_s = ST_IDLE;
                    sel1_nxt_s  = regSel1;
                    sel2_nxt_s  = regSel2;
                    cnt_nxt_s   = '0;
                    err_nxt_s   = 1'b0;
                end else if (cnt_r >= dwell_lat_r) begin
                    // Range edits are only acted on once the current dwell ends.
                    if (!range_ok_s) begin
                        state_nxt_s = ST_IDLE;
                        sel1_nxt_s  = regSel1;
                        sel2_nxt_s  = regSel2;
                        cnt_nxt_s   = '0;
                        err_nxt_s   = 1'b1;
                    end else begin
                        sel1_nxt_s      = scan_next_sel(sel1_r, scanStart, scanEnd);
                        sel2_nxt_s      = regSel2;
                        cnt_nxt_s       = DWELL_W'(1);
                        dwell_lat_nxt_s = dwell_eff_s;
                    end
                end else begin
                    sel2_nxt_s = regSel2;
                    cnt_nxt_s  = cnt_r + DWELL_W'(1);
                end
            end
            ST_FROZEN: begin
                if (trigClr) begin
                    state_nxt_s = ST_IDLE;
                    hit_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_FROZEN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sel1_nxt_s  = regSel1;
                sel2_nxt_s  = regSel2;
                cnt_nxt_s   = '0;
                hit_nxt_s   = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s == ST_SCAN);
    end

    // FSM state register.
    always_ff @(posedge macCoreClk) begin
        if (!macCoreClkSoftRst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Selection, dwell, status and capture registers.
    always_ff @(posedge macCoreClk) begin
        if (!macCoreClkSoftRst_n) begin
            sel1_r      <= '0;
            sel2_r      <= '0;
            cnt_r       <= '0;
            dwell_lat_r <= DWELL_W'(1);
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            hit_r       <= 1'b0;
            trig_sel_r  <= '0;
            trig_cap_r  <= '0;
        end else begin
            sel1_r      <= sel1_nxt_s;
            sel2_r      <= sel2_nxt_s;
            cnt_r       <= cnt_nxt_s;
            dwell_lat_r <= dwell_lat_nxt_s;
            busy_r      <= busy_nxt_s;
            err_r       <= err_nxt_s;
            hit_r       <= hit_nxt_s;
            trig_sel_r  <= trig_sel_nxt_s;
            trig_cap_r  <= trig_cap_nxt_s;
        end
    end

    assign debugPortSel1 = sel1_r;
    assign debugPortSel2 = sel2_r;
    assign scanBusy      = busy_r;
    assign scanErr       = err_r;
    assign trigHit       = hit_r;
    assign trigSel       = trig_sel_r;
    assign trigCapture   = trig_cap_r;

endmodule

// File: tb/tb_debug_port_scan_ctrl.sv
// Directed bench for debug_port_scan_ctrl with a small behavioural debug mux.
module tb_debug_port_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  reg_sel1, reg_sel2;
    logic        scan_en;
    logic [7:0]  scan_start, scan_end;
    logic [15:0] dwell;
    logic        trig_en;
    logic [15:0] trig_mask, trig_value;
    logic        trig_clr;
    logic [31:0] debug_port;
    logic [7:0]  sel1, sel2;
    logic        busy, err, hit;
    logic [7:0]  trig_sel;
    logic [31:0] trig_cap;

    int n_checks = 0;
    int n_fail   = 0;

    debug_port_scan_ctrl #(.MAX_SEL(47), .DWELL_W(16)) dut (
        .macCoreClk          (clk),
        .macCoreClkSoftRst_n (rst_n),
        .regSel1             (reg_sel1),
        .regSel2             (reg_sel2),
        .scanEn              (scan_en),
        .scanStart           (scan_start),
        .scanEnd             (scan_end),
        .dwell               (dwell),
        .trigEn              (trig_en),
        .trigMask            (trig_mask),
        .trigValue           (trig_value),
        .trigClr             (trig_clr),
        .debugPort           (debug_port),
        .debugPortSel1       (sel1),
        .debugPortSel2       (sel2),
        .scanBusy            (busy),
        .scanErr             (err),
        .trigHit             (hit),
        .trigSel             (trig_sel),
        .trigCapture         (trig_cap)
    );

    // Selection 3 presents 0xAB12 on the high half; others never match low byte 0x12.
    function automatic logic [31:0] mux_model(input logic [7:0] s1, input logic [7:0] s2);
        logic [15:0] hi;
        if (s1 == 8'd3) hi = 16'hAB12;
        else            hi = {s1, 8'h00};
        return {hi, s2, s1};
    endfunction

    assign debug_port = mux_model(sel1, sel2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] seq_d3 [10] = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4, 8'd2};
    logic [7:0] seq_d0 [4]  = '{8'd2, 8'd3, 8'd4, 8'd2};

    initial begin
        rst_n = 1'b0; reg_sel1 = 8'd0; reg_sel2 = 8'd0; scan_en = 1'b0;
        scan_start = 8'd0; scan_end = 8'd0; dwell = 16'd0; trig_en = 1'b0;
        trig_mask = 16'h0000; trig_value = 16'h0000; trig_clr = 1'b0;
        step(2);
        check("rst_sel1", sel1, 32'd0);
        check("rst_sel2", sel2, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_hit", hit, 32'd0);
        check("rst_trig_sel", trig_sel, 32'd0);
        check("rst_capture", trig_cap, 32'd0);

        // Static selection
        rst_n = 1'b1; reg_sel1 = 8'd5; reg_sel2 = 8'd9;
        step(1);
        check("static_sel1", sel1, 32'd5);
        check("static_sel2", sel2, 32'd9);

        // Scan wrap with dwell 3
        scan_start = 8'd2; scan_end = 8'd4; dwell = 16'd3; scan_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("scan_d3_%0d", i), sel1, 32'(seq_d3[i]));
        end
        check("scan_busy", busy, 32'd1);
        check("scan_sel2", sel2, 32'd9);
        scan_en = 1'b0;
        step(1);
        check("scan_off_sel1", sel1, 32'd5);
        check("scan_off_busy", busy, 32'd0);

        // Scan wrap with dwell 0 (treated as 1)
        dwell = 16'd0; scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("scan_d0_%0d", i), sel1, 32'(seq_d0[i]));
        end
        scan_en = 1'b0;
        step(1);

        // Invalid ranges
        scan_start = 8'd6; scan_end = 8'd3; scan_en = 1'b1;
        step(1);
        check("inv_rev_err", err, 32'd1);
        check("inv_rev_busy", busy, 32'd0);
        check("inv_rev_sel1", sel1, 32'd5);
        scan_start = 8'd2; scan_end = 8'd48;
        step(1);
        check("inv_max_err", err, 32'd1);
        check("inv_max_busy", busy, 32'd0);
        check("inv_max_sel1", sel1, 32'd5);
        scan_en = 1'b0;
        step(1);
        check("inv_clear_err", err, 32'd0);

        // Trigger during scan
        trig_mask = 16'h00FF; trig_value = 16'h0012; trig_en = 1'b1;
        scan_start = 8'd2; scan_end = 8'd4; dwell = 16'd2; scan_en = 1'b1;
        step(3);
        check("trig_pre_sel1", sel1, 32'd3);
        check("trig_pre_hit", hit, 32'd0);
        step(1);
        check("trig_hit", hit, 32'd1);
        check("trig_sel", trig_sel, 32'd3);
        check("trig_capture", trig_cap, 32'hAB12_0903);
        check("trig_busy", busy, 32'd0);
        step(3);
        check("frozen_sel1", sel1, 32'd3);
        check("frozen_hit", hit, 32'd1);
        scan_en = 1'b0;
        step(2);
        check("frozen_scanoff_hit", hit, 32'd1);
        trig_clr = 1'b1; trig_en = 1'b0;
        step(1);
        trig_clr = 1'b0;
        check("clr_hit", hit, 32'd0);
        step(1);
        check("clr_idle_sel1", sel1, 32'd5);
        check("clr_keep_trig_sel", trig_sel, 32'd3);
        check("clr_keep_capture", trig_cap, 32'hAB12_0903);

        // Trigger and clear on the same edge in SCAN
        reg_sel2 = 8'h21; trig_en = 1'b1; dwell = 16'd1; scan_en = 1'b1;
        step(2);
        check("sim_pre_sel1", sel1, 32'd3);
        trig_clr = 1'b1;
        step(1);
        trig_clr = 1'b0;
        check("sim_hit", hit, 32'd1);
        check("sim_capture", trig_cap, 32'hAB12_2103);
        scan_en = 1'b0;
        step(2);
        check("sim_frozen_hit", hit, 32'd1);
        check("sim_frozen_sel1", sel1, 32'd3);
        check("sim_frozen_busy", busy, 32'd0);

        // Reset while frozen
        rst_n = 1'b0;
        step(1);
        check("frz_rst_sel1", sel1, 32'd0);
        check("frz_rst_sel2", sel2, 32'd0);
        check("frz_rst_hit", hit, 32'd0);
        check("frz_rst_trig_sel", trig_sel, 32'd0);
        check("frz_rst_capture", trig_cap, 32'd0);
        rst_n = 1'b1; trig_en = 1'b0; scan_en = 1'b1;
        step(1);
        check("restart_sel1", sel1, 32'd2);
        check("restart_busy", busy, 32'd1);

        // Range moved mid-scan, then made invalid
        scan_start = 8'd10; scan_end = 8'd12;
        step(1);
        check("newrange_sel1", sel1, 32'd10);
        scan_end = 8'd9;
        step(1);
        check("badrange_err", err, 32'd1);
        check("badrange_busy", busy, 32'd0);
        check("badrange_sel1", sel1, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_port_scan_ctrl.md
DEBUG_PORT_SCAN_CTRL -- requirements
Module: debug_port_scan_ctrl

Interface
REQ-001 SHALL have parameter MAX_SEL, default 47, the highest valid debug mux selection code.
REQ-002 SHALL have parameter DWELL_W, default 16, the dwell counter width.
REQ-003 macCoreClk  in  1  sole clock; all logic rising-edge.
REQ-004 macCoreClkSoftRst_n  in  1  reset, synchronous, active-low.
REQ-005 regSel1/regSel2  in  8 each  static selections for the low and high debug halves.
REQ-006 scanEn  in  1  level; 1 = auto-scan of low-half selection.
REQ-007 scanStart/scanEnd  in  8 each  inclusive scan range.
REQ-008 dwell  in  DWELL_W  cycles each selection is held; 0 treated as 1.
REQ-009 trigEn  in  1  arms the trigger; trigMask/trigValue  in  16 each  match on the high half.
REQ-010 trigClr  in  1  pulse; releases freeze.
REQ-011 debugPort  in  32  mux output fed back (combinational from the selections).
REQ-012 debugPortSel1/debugPortSel2  out  8 each  registered selections to the mux.
REQ-013 scanBusy, scanErr, trigHit  out  1 each  status.
REQ-014 trigSel  out  8  debugPortSel1 at trigger; trigCapture  out  32  debugPort at trigger.

Function
REQ-015 SHALL implement states IDLE, SCAN, FROZEN.
REQ-016 IDLE: Sel1=regSel1, Sel2=regSel2, updated one cycle after a register change.
REQ-017 IDLE->SCAN when scanEn=1, scanStart<=scanEnd and scanEnd<=MAX_SEL; Sel1 loads scanStart on the entry cycle.
REQ-018 If scanEn=1 with an invalid range: stay IDLE and set scanErr=1; clear scanErr when scanEn=0 or the range becomes valid.
REQ-019 SCAN: Sel2=regSel2; Sel1 held for max(dwell,1) cycles, then incremented; after scanEnd, wrap to scanStart with no gap cycle.
REQ-020 Dwell counter SHALL restart on every Sel1 change; a dwell write mid-scan takes effect at the next selection.
REQ-021 scanBusy=1 only in SCAN.
REQ-022 Trigger match when trigEn=1 and (debugPort[31:16] & trigMask)==(trigValue & trigMask), sampled in IDLE or SCAN.
REQ-023 On match: next state FROZEN; in the same edge, trigCapture<=debugPort, trigSel<=debugPortSel1, trigHit<=1.
REQ-024 FROZEN: hold both selections and the dwell counter; ignore new matches.
REQ-025 FROZEN->IDLE on trigClr; trigHit cleared in the same edge.
REQ-026 trigCapture and trigSel SHALL be retained until the next trigger.
REQ-027 scanEn=0 in SCAN -> IDLE next edge, with selections reverting to the static values.
REQ-028 scanEn changes in FROZEN are ignored until trigClr.
REQ-029 trigClr together with a match in IDLE/SCAN: trigger wins.
REQ-030 trigClr outside FROZEN: no effect.
REQ-031 Range registers changed mid-scan: current Sel1 completes its dwell; if the new range is invalid -> IDLE with scanErr=1; if Sel1 is outside the new valid range, next step loads scanStart.

Reset
REQ-032 On reset low at an edge: state IDLE, Sel1=Sel2=0, counter 0, scanBusy=scanErr=trigHit=0, trigSel=0, trigCapture=0.
REQ-033 Reset mid-scan or mid-freeze SHALL abort at once; no capture is retained.

Structure
REQ-034 The state enum, MAX_SEL default and selection width (8) SHALL live in the shared debug package.
REQ-035 The trigger comparator SHALL be one sub-module, debug_trig_match (mask/value compare, combinational).
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Static: scanEn=0, regSel1=5, regSel2=9 -> Sel1=5, Sel2=9 one cycle later.
REQ-038 Scan wrap: scanStart=2, scanEnd=4, dwell=3 -> Sel1 sequence 2,2,2,3,3,3,4,4,4,2; dwell=0 -> 2,3,4,2.
REQ-039 Invalid range: scanStart=6, scanEnd=3 -> scanErr=1, scanBusy=0, Sel1=regSel1; same for scanEnd=MAX_SEL+1.
REQ-040 Trigger: mask=0x00FF, value=0x0012, debugPort=0xAB12_xxxx while Sel1=3 -> trigHit=1, trigSel=3, capture=debugPort, Sel1 frozen; trigClr -> IDLE, trigHit=0.
REQ-041 Simultaneous trigClr and match in SCAN -> FROZEN; scanEn=0 in FROZEN -> still FROZEN.
REQ-042 Reset asserted in FROZEN -> all outputs 0 next edge; afterwards scanEn=1 restarts from scanStart.
